// File: rtl/shift_sched_pkg.sv
// shift_sched_pkg: shared FSM states, stage command encoding and default per-cycle shift limit
package shift_sched_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {
    CMD_HOLD  = 2'b00,
    CMD_LEFT  = 2'b01,
    CMD_RIGHT = 2'b10,
    CMD_LOAD  = 2'b11
  } cmd_t;
  localparam int STEP_MAX_DEF = 7;
endpackage

// File: rtl/shift_stage.sv
// shift_stage: 8-bit registered shifter/rotator driven by a 2-bit command and 3-bit step
module shift_stage
  import shift_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  cmd_t       cmd,
  input  logic [2:0] step,
  input  logic       rot,
  input  logic [7:0] d,
  output logic [7:0] q
);
  logic [7:0] stage_q, stage_d;
  logic [15:0] dbl_l, dbl_r;
  always_comb begin
    dbl_l = {stage_q, stage_q} << step;
    dbl_r = {stage_q, stage_q} >> step;
    stage_d = cmd == CMD_LOAD  ? d
            : cmd == CMD_LEFT  ? (rot ? dbl_l[15:8] : stage_q << step)
            : cmd == CMD_RIGHT ? (rot ? dbl_r[7:0]  : stage_q >> step)
            : stage_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stage_q <= '0;
    else stage_q <= stage_d;
  assign q = stage_q;
endmodule

// File: rtl/shift_sched.sv
// shift_sched: two-requester round-robin multi-cycle shifter; SHIFT_SCHED_ROTATE_EN enables rotate
module shift_sched
  import shift_sched_pkg::*;
#(
  parameter int AMT_W    = 4,
  parameter int STEP_MAX = STEP_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic             dir0,
  input  logic             dir1,
  input  logic             rot0,
  input  logic             rot1,
  input  logic [AMT_W-1:0] amt0,
  input  logic [AMT_W-1:0] amt1,
  input  logic [7:0]       din0,
  input  logic [7:0]       din1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic [7:0]       dout,
  output logic             busy
);
  state_t state_q, state_d;
  logic last_q, last_d, owner_q, owner_d, dir_q, dir_d, rot_q, rot_d;
  logic [AMT_W-1:0] amt_q, amt_d, rem_q, rem_d;
  logic [7:0] din_q, din_d, dout_q, dout_d, stage;
  cmd_t cmd;
  logic [2:0] step;
  logic win, sel_rot;
  assign win = (req0 & req1) ? ~last_q : req1;
`ifdef SHIFT_SCHED_ROTATE_EN
  assign sel_rot = win ? rot1 : rot0;
`else
  assign sel_rot = 1'b0 & (win ? rot1 : rot0);
`endif
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    dir_d   = dir_q;
    rot_d   = rot_q;
    amt_d   = amt_q;
    din_d   = din_q;
    rem_d   = rem_q;
    dout_d  = dout_q;
    cmd     = CMD_HOLD;
    step    = (int'(rem_q) < STEP_MAX) ? rem_q[2:0] : 3'(STEP_MAX);
    case (state_q)
      IDLE: if (req0 | req1) begin
        state_d = LOAD;
        last_d  = win;
        owner_d = win;
        dir_d   = win ? dir1 : dir0;
        rot_d   = sel_rot;
        amt_d   = win ? amt1 : amt0;
        din_d   = win ? din1 : din0;
      end
      LOAD: begin
        cmd     = CMD_LOAD;
        rem_d   = amt_q;
        state_d = amt_q != '0 ? SHIFT : DONE;
      end
      SHIFT: begin
        cmd     = dir_q ? CMD_RIGHT : CMD_LEFT;
        rem_d   = rem_q - AMT_W'(step);
        state_d = rem_q == AMT_W'(step) ? DONE : SHIFT;
      end
      default: begin
        dout_d  = stage;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      amt_q   <= '0;
      din_q   <= '0;
      rem_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      dir_q   <= dir_d;
      rot_q   <= rot_d;
      amt_q   <= amt_d;
      din_q   <= din_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
    end
  shift_stage u_stage (
    .clk   (clk),
    .rst_n (rst_n),
    .cmd   (cmd),
    .step  (step),
    .rot   (rot_q),
    .d     (din_q),
    .q     (stage)
  );
  assign gnt  = state_q == LOAD ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign done = state_q == DONE ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy = state_q != IDLE;
  assign dout = state_q == DONE ? stage : dout_q;
endmodule

// File: tb/tb_shift_sched.sv
// tb_shift_sched: vector table plus scoreboard of expected completions for shift_sched
module tb_shift_sched;
`ifdef SHIFT_SCHED_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 0, req1 = 0, dir0 = 0, dir1 = 0, rot0 = 0, rot1 = 0;
  logic [3:0] amt0 = 0, amt1 = 0;
  logic [7:0] din0 = 0, din1 = 0;
  logic [1:0] gnt, done;
  logic [7:0] dout;
  logic busy;
  always #5 clk = ~clk;
  shift_sched dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .dir0(dir0), .dir1(dir1),
    .rot0(rot0), .rot1(rot1), .amt0(amt0), .amt1(amt1), .din0(din0), .din1(din1),
    .gnt(gnt), .done(done), .dout(dout), .busy(busy)
  );
  typedef struct {logic sel, dir, rot; logic [3:0] amt; logic [7:0] din, dout; int lat;} vec_t;
  typedef struct {logic owner; logic [7:0] dout; int lat;} exp_t;
  exp_t sb[$];
  vec_t vecs[8];
  int compared = 0, mismatched = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask
  function automatic logic [7:0] model(input logic dir, rot, input logic [3:0] amt, input logic [7:0] din);
    logic [15:0] w;
    logic [2:0] r;
    r = amt[2:0];
    if (rot && ROT_EN) begin
      w = dir ? {din, din} >> r : {din, din} << r;
      return dir ? w[7:0] : w[15:8];
    end
    if (amt >= 4'd8) return 8'h00;
    return dir ? din >> amt : din << amt;
  endfunction
  task automatic wait_gnt(input logic [1:0] want);
    int n = 0;
    while (gnt == 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("gnt", 32'(gnt), 32'(want));
  endtask
  task automatic collect(input int n0);
    int n = n0;
    exp_t e;
    while (done == 2'b00 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("done", 32'(done), e.owner ? 32'h2 : 32'h1);
    check("dout", 32'(dout), 32'(e.dout));
    if (e.lat != 0) check("latency", n, e.lat);
  endtask
  task automatic drive(input vec_t v);
    if (v.sel) begin
      req1 = 1; dir1 = v.dir; rot1 = v.rot; amt1 = v.amt; din1 = v.din;
    end else begin
      req0 = 1; dir0 = v.dir; rot0 = v.rot; amt0 = v.amt; din0 = v.din;
    end
  endtask
  task automatic run_op(input vec_t v);
    @(negedge clk);
    drive(v);
    sb.push_back('{v.sel, v.dout, v.lat});
    @(negedge clk);
    check("gnt_op", 32'(gnt), v.sel ? 32'h2 : 32'h1);
    check("busy", 32'(busy), 1);
    req0 = 0; req1 = 0;
    collect(1);
    @(negedge clk);
    check("dout_hold", 32'(dout), 32'(v.dout));
    check("done_pulse", 32'(done), 0);
    check("idle", 32'(busy), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vec_t v;
    logic [1:0] dsum;
    vecs[0] = '{1'b0, 1'b0, 1'b0, 4'd3,  8'h81, 8'h08, 3};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 4'd10, 8'hF0, 8'h00, 4};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 4'd0,  8'hA5, 8'hA5, 2};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 4'd1,  8'h81, ROT_EN ? 8'h03 : 8'h02, 3};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 4'd7,  8'hFF, 8'h80, 3};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 4'd8,  8'hFF, 8'h00, 4};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 4'd15, 8'h81, ROT_EN ? 8'hC0 : 8'h00, 5};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 4'd9,  8'h12, ROT_EN ? 8'h09 : 8'h00, 4};
    req0 = 1; dir0 = 0; amt0 = 4'd2; din0 = 8'h0F;
    req1 = 1; dir1 = 1; amt1 = 4'd4; din1 = 8'hF0;
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 0);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_done", 32'(done), 0);
    check("rst_busy", 32'(busy), 0);
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{1'b0, 8'h3C, 3});
      sb.push_back('{1'b1, 8'h0F, 3});
      if (k == 0) rst_n = 1;
      else begin
        req0 = 1; req1 = 1;
      end
      @(negedge clk);
      check("tie_first", 32'(gnt), 32'h1);
      req0 = 0;
      collect(1);
      @(negedge clk);
      wait_gnt(2'b10);
      req1 = 0;
      collect(1);
      @(negedge clk);
    end
    foreach (vecs[i]) run_op(vecs[i]);
    for (int i = 0; i < 6; i++) begin
      v.sel = 1'($urandom_range(0, 1));
      v.dir = 1'($urandom_range(0, 1));
      v.rot = 1'($urandom_range(0, 1));
      v.amt = 4'($urandom_range(0, 15));
      v.din = 8'($urandom_range(0, 255));
      v.dout = model(v.dir, v.rot, v.amt, v.din);
      v.lat = 2 + (int'(v.amt) + 6) / 7;
      run_op(v);
    end
    @(negedge clk);
    req0 = 1; dir0 = 0; rot0 = 0; amt0 = 4'd14; din0 = 8'hFF;
    @(negedge clk);
    req0 = 0;
    @(negedge clk);
    rst_n = 0;
    #1;
    check("abort_dout", 32'(dout), 0);
    check("abort_gnt", 32'(gnt), 0);
    check("abort_busy", 32'(busy), 0);
    dsum = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dsum = dsum | done;
    end
    check("abort_no_done", 32'(dsum), 0);
    rst_n = 1;
    run_op('{1'b1, 1'b0, 1'b0, 4'd3, 8'h81, 8'h08, 3});
    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
